// File: rtl/qei_input_filter.sv
// -----------------------------------------------------------------------------
// qei_input_filter
//
// Conditions the three raw quadrature-encoder pins (A, B, index Z) before they
// reach the decoder. Each channel gets its own synchronizer chain. After that,
// a debounce filter passes a new level only once the synced sample has held it
// for FILT_LEN consecutive cycles. If A and B both change on the same edge,
// that step is illegal for a quadrature encoder, so it is flagged as an error
// and counted.
//
// Parameters
//   SYNC_STAGES  synchronizer depth per channel (2..4)
//   FILT_LEN     consecutive synced samples needed to accept a level (2..16)
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   rst          synchronous, active-high reset
//   a_in/b_in/z_in  raw asynchronous encoder pins
//   err_clr      synchronous clear of err_cnt (wins over a same-cycle count)
//   a/b/z        filtered channels, driven straight from flops
//   err          one-cycle pulse, the cycle after a and b changed together
//   err_cnt      saturating count of err pulses
//
// Latency of a clean level change: SYNC_STAGES + FILT_LEN rising edges,
// counted from the first edge that samples the new level.
// -----------------------------------------------------------------------------
module qei_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       z_in,
  input  logic       err_clr,
  output logic       a,
  output logic       b,
  output logic       z,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam int NCH = 3;
  localparam int CW  = $clog2(FILT_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  // Channel index order: 0 = A, 1 = B, 2 = Z.
  logic [NCH-1:0]         raw;
  logic [SYNC_STAGES-1:0] sync_q [NCH];
  logic [CW-1:0]          cnt_q  [NCH];
  logic [NCH-1:0]         filt_q;
  logic [1:0]             ab_d;   // filtered A/B one cycle ago
  logic                   ab_both;

  assign raw = {z_in, b_in, a_in};

  // Both A and B outputs differ from their previous-cycle values. This means
  // they were reloaded on the same edge.
  assign ab_both = (filt_q[0] != ab_d[0]) && (filt_q[1] != ab_d[1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      filt_q  <= '0;
      ab_d    <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every stage reads the value
      // from before this edge. That is what makes the chain a real shift
      // register, and what keeps the filter working on the registered sample.
      for (int i = 0; i < NCH; i++) begin
        if (SYNC_STAGES > 1) begin
          sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        end else begin
          sync_q[i] <= raw[i];
        end

        // Any sample that matches the output clears the count. A level that
        // reverts mid-qualification therefore starts again from zero.
        if (sync_q[i][SYNC_STAGES-1] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          filt_q[i] <= sync_q[i][SYNC_STAGES-1];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end

      ab_d <= filt_q[1:0];
      err  <= ab_both;

      if (err_clr) begin
        err_cnt <= '0;
      end else if (ab_both && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  assign a = filt_q[0];
  assign b = filt_q[1];
  assign z = filt_q[2];

endmodule

// File: doc/qei_input_filter.md
QEI_INPUT_FILTER -- requirements
Module: qei_input_filter

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2, synchronizer depth per channel (legal 2..4).
REQ-002 SHALL provide parameter FILT_LEN, default 4, consecutive synced samples required to accept a new level (legal 2..16).
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide ports a_in, b_in, z_in  input  1 each  raw asynchronous encoder channels from the pins.
REQ-006 SHALL provide ports a, b, z  output  1 each  filtered channels feeding fpgadecoder inputs a, b, z.
REQ-007 SHALL provide port err  output  1  one-cycle pulse: a and b both updated in the same cycle, which is an illegal quadrature step.
REQ-008 SHALL provide port err_cnt  output  8  saturating count of err pulses.
REQ-009 SHALL provide port err_clr  input  1  synchronous clear of err_cnt.

Function
REQ-010 SHALL pass each of a_in, b_in, z_in through its own chain of SYNC_STAGES flops; the last stage is the channel's synced sample s.
REQ-011 SHALL keep one qualification counter per channel, width clog2(FILT_LEN).
REQ-012 SHALL clear the channel counter on any cycle where s equals the channel output.
REQ-013 SHALL increment the channel counter when s differs from the output and counter < FILT_LEN-1.
REQ-014 SHALL load the output with s and clear the counter when s differs from the output and counter == FILT_LEN-1.
REQ-015 SHALL give a clean level change on x_in a latency of exactly SYNC_STAGES+FILT_LEN rising edges to x, counted from the first edge that samples the new level. Defaults give 6.
REQ-016 SHALL reject any pulse or glitch whose synced width is < FILT_LEN cycles; output unchanged and counter returns to 0.
REQ-017 SHALL restart qualification from 0 when the level reverts mid-qualification; no partial credit is carried over.
REQ-018 SHALL process channels independently; z filtering never affects a/b or err.
REQ-019 SHALL assert err for exactly one cycle, in the cycle after a and b both change on the same edge; z is ignored for err.
REQ-020 SHALL increment err_cnt by 1 per err pulse and saturate at 255 without wrapping.
REQ-021 SHALL give err_clr priority over a coincident increment: err_cnt becomes 0 and that event is not counted; the err pulse itself still asserts.
REQ-022 SHALL keep outputs glitch-free: a, b, z, err and err_cnt are driven directly from flops.

Reset
REQ-023 SHALL, while rst=1 at a rising edge, set all synchronizer flops, counters, a, b, z, err and err_cnt to 0.
REQ-024 SHALL, on reset asserted mid-qualification, abandon the pending change; after release, any input level of 1 requires full SYNC_STAGES+FILT_LEN cycles to reach the output.
REQ-025 SHALL ignore err_clr and all inputs during reset.

Verification
REQ-026 SHALL verify: defaults, reset released, a_in 0->1 held -> a=0 for 5 edges, a=1 at 6th edge; b, z, err stay 0.
REQ-027 SHALL verify: 3-cycle high pulse on b_in (FILT_LEN=4) -> b stays 0; a following 4-cycle pulse -> b high for exactly 4 cycles, delayed by 6.
REQ-028 SHALL verify: a_in and b_in toggle on the same edge and hold -> a and b change on the same edge, err=1 for one cycle next, err_cnt=1.
REQ-029 SHALL verify: 300 simultaneous a/b toggles spaced 10 cycles -> err_cnt=255 and held; then err_clr for 1 cycle -> err_cnt=0.
REQ-030 SHALL verify: rst pulsed 3 edges after a_in rises -> a never goes 1 before 6 edges after rst deasserts; counters restart.
REQ-031 SHALL verify: forward quadrature (00,01,11,10,00) at 10 cycles/step plus z pulse of 8 cycles -> a, b, z reproduce the sequence shifted by 6 cycles; err never asserts; err_cnt=0.
